// File: rtl/cpu_pkg.sv
// Shared CPU-core definitions: default datapath widths, opcode encoding,
// scoreboard counter width and a small ceil-log2 helper.
package cpu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    // In-flight writers per register are tracked by a saturating counter.
    localparam int               SB_W   = 2;
    localparam logic [SB_W-1:0]  SB_MAX = '1;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_LD  = 4'h6,
        OP_ST  = 4'h7,
        OP_BR  = 4'h8,
        OP_JMP = 4'h9
    } opcode_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rf_bypass_sel.sv
// One read port: picks the youngest in-flight producer (EX > MEM > WB) or
// falls back to the architectural register and its scoreboard state.
module rf_bypass_sel
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              ex_wr_i,
    input  logic [ADDR_W-1:0] ex_dst_i,
    input  logic              ex_dv_i,
    input  logic [DATA_W-1:0] ex_data_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_dst_i,
    input  logic              mem_dv_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              wb_wr_i,
    input  logic [ADDR_W-1:0] wb_dst_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [DATA_W-1:0] gr_data_i,
    input  logic              cnt_zero_i,
    output logic [DATA_W-1:0] data_o,
    output logic              ready_o
);

    always_comb begin
        data_o  = gr_data_i;
        ready_o = cnt_zero_i;
        if ((ZERO_REG != 0) && (addr_i == '0)) begin
            data_o  = '0;
            ready_o = 1'b1;
        end else if (ex_wr_i && (ex_dst_i == addr_i)) begin
            data_o  = ex_data_i;
            ready_o = ex_dv_i;
        end else if (mem_wr_i && (mem_dst_i == addr_i)) begin
            data_o  = mem_data_i;
            ready_o = mem_dv_i;
        end else if (wb_wr_i && (wb_dst_i == addr_i)) begin
            // Write-first: the value being written this cycle is visible now.
            data_o  = wb_data_i;
            ready_o = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_regfile_sb.sv
// General register file with per-register write scoreboard, EX/MEM/WB
// operand forwarding and load-use / scoreboard-full stall generation.
module cpu_regfile_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_PORTS = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         en,
    input  logic [RD_PORTS-1:0]          rd_need,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_ready,
    input  logic                         iss_valid,
    input  logic [ADDR_W-1:0]            iss_dst,
    input  logic                         ex_wr,
    input  logic [ADDR_W-1:0]            ex_dst,
    input  logic                         ex_dv,
    input  logic [DATA_W-1:0]            ex_data,
    input  logic                         mem_wr,
    input  logic [ADDR_W-1:0]            mem_dst,
    input  logic                         mem_dv,
    input  logic [DATA_W-1:0]            mem_data,
    input  logic                         wb_wr,
    input  logic [ADDR_W-1:0]            wb_dst,
    input  logic [DATA_W-1:0]            wb_data,
    output logic                         stall,
    output logic [(1<<ADDR_W)-1:0]       pend,
    output logic                         sb_err
);

    localparam int REG_N = 1 << ADDR_W;

    logic [DATA_W-1:0] gr_q  [REG_N];
    logic [DATA_W-1:0] gr_d  [REG_N];
    logic [SB_W-1:0]   cnt_q [REG_N];
    logic [SB_W-1:0]   cnt_d [REG_N];
    logic              sb_err_q;
    logic              sb_err_d;

    logic [REG_N-1:0]    inc_v;
    logic [REG_N-1:0]    dec_v;
    logic [RD_PORTS-1:0] need_miss;
    logic                iss_fire;
    logic                wb_fire;

    assign iss_fire = en & iss_valid & ~stall;
    assign wb_fire  = en & wb_wr;

    genvar gi;
    generate
        for (gi = 0; gi < REG_N; gi = gi + 1) begin : g_reg
            // With a hard-wired zero register, r0 never tracks writers.
            localparam bit FIXED = (ZERO_REG != 0) && (gi == 0);
            assign inc_v[gi] = iss_fire & (iss_dst == ADDR_W'(gi)) & ~FIXED;
            assign dec_v[gi] = wb_fire  & (wb_dst  == ADDR_W'(gi)) & ~FIXED;
            assign pend[gi]  = (cnt_q[gi] != '0);
        end

        for (gi = 0; gi < RD_PORTS; gi = gi + 1) begin : g_port
            rf_bypass_sel #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG)
            ) u_sel (
                .addr_i     (rd_addr[gi*ADDR_W +: ADDR_W]),
                .ex_wr_i    (ex_wr),
                .ex_dst_i   (ex_dst),
                .ex_dv_i    (ex_dv),
                .ex_data_i  (ex_data),
                .mem_wr_i   (mem_wr),
                .mem_dst_i  (mem_dst),
                .mem_dv_i   (mem_dv),
                .mem_data_i (mem_data),
                .wb_wr_i    (wb_wr),
                .wb_dst_i   (wb_dst),
                .wb_data_i  (wb_data),
                .gr_data_i  (gr_q[rd_addr[gi*ADDR_W +: ADDR_W]]),
                .cnt_zero_i (cnt_q[rd_addr[gi*ADDR_W +: ADDR_W]] == '0),
                .data_o     (rd_data[gi*DATA_W +: DATA_W]),
                .ready_o    (rd_ready[gi])
            );
            assign need_miss[gi] = rd_need[gi] & ~rd_ready[gi];
        end
    endgenerate

    // Stall on any unready needed operand, or when the destination counter is full.
    assign stall  = (|need_miss) | (iss_valid & (cnt_q[iss_dst] == SB_MAX));
    assign sb_err = sb_err_q;

    always_comb begin
        sb_err_d = sb_err_q;
        for (int r = 0; r < REG_N; r++) begin
            gr_d[r]  = gr_q[r];
            cnt_d[r] = cnt_q[r];
            if (dec_v[r]) begin
                gr_d[r] = wb_data;
            end
            if (inc_v[r] && !dec_v[r]) begin
                if (cnt_q[r] != SB_MAX) begin
                    cnt_d[r] = cnt_q[r] + SB_W'(1);
                end
            end else if (dec_v[r] && !inc_v[r]) begin
                if (cnt_q[r] == '0) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - SB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < REG_N; r++) begin
                gr_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < REG_N; r++) begin
                gr_q[r]  <= gr_d[r];
                cnt_q[r] <= cnt_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

endmodule

// File: tb/tb_cpu_regfile_sb.sv
// Scoreboard bench: two DUTs (ZERO_REG=0 and 1) share stimulus; expected
// outputs come from an array/counter reference model and are checked by a monitor.
module tb_cpu_regfile_sb;

    typedef struct packed {
        logic        rst_n;
        logic        en;
        logic [1:0]  need;
        logic [5:0]  addr;
        logic        iv;
        logic [2:0]  idst;
        logic        exw;
        logic [2:0]  exd;
        logic        exv;
        logic [15:0] exdat;
        logic        mw;
        logic [2:0]  md;
        logic        mv;
        logic [15:0] mdat;
        logic        ww;
        logic [2:0]  wd;
        logic [15:0] wdat;
    } stim_t;

    typedef struct packed {
        logic        inst;
        logic [31:0] data;
        logic [1:0]  ready;
        logic        stall;
        logic [7:0]  pend;
        logic        err;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        en;
    logic [1:0]  rd_need;
    logic [5:0]  rd_addr;
    logic        iss_valid;
    logic [2:0]  iss_dst;
    logic        ex_wr, mem_wr, wb_wr;
    logic [2:0]  ex_dst, mem_dst, wb_dst;
    logic        ex_dv, mem_dv;
    logic [15:0] ex_data, mem_data, wb_data;

    logic [31:0] dat_w   [2];
    logic [1:0]  rdy_w   [2];
    logic        stall_w [2];
    logic [7:0]  pend_w  [2];
    logic        err_w   [2];

    cpu_regfile_sb #(.DATA_W(16), .ADDR_W(3), .RD_PORTS(2), .ZERO_REG(0)) u_dut0 (
        .clock(clock), .reset(reset), .en(en), .rd_need(rd_need), .rd_addr(rd_addr),
        .rd_data(dat_w[0]), .rd_ready(rdy_w[0]), .iss_valid(iss_valid), .iss_dst(iss_dst),
        .ex_wr(ex_wr), .ex_dst(ex_dst), .ex_dv(ex_dv), .ex_data(ex_data),
        .mem_wr(mem_wr), .mem_dst(mem_dst), .mem_dv(mem_dv), .mem_data(mem_data),
        .wb_wr(wb_wr), .wb_dst(wb_dst), .wb_data(wb_data),
        .stall(stall_w[0]), .pend(pend_w[0]), .sb_err(err_w[0])
    );

    cpu_regfile_sb #(.DATA_W(16), .ADDR_W(3), .RD_PORTS(2), .ZERO_REG(1)) u_dut1 (
        .clock(clock), .reset(reset), .en(en), .rd_need(rd_need), .rd_addr(rd_addr),
        .rd_data(dat_w[1]), .rd_ready(rdy_w[1]), .iss_valid(iss_valid), .iss_dst(iss_dst),
        .ex_wr(ex_wr), .ex_dst(ex_dst), .ex_dv(ex_dv), .ex_data(ex_data),
        .mem_wr(mem_wr), .mem_dst(mem_dst), .mem_dv(mem_dv), .mem_data(mem_data),
        .wb_wr(wb_wr), .wb_dst(wb_dst), .wb_data(wb_data),
        .stall(stall_w[1]), .pend(pend_w[1]), .sb_err(err_w[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: architectural values, writer counts, sticky error.
    logic [15:0] m_gr  [2][8];
    int          m_cnt [2][8];
    logic        m_err [2];

    exp_t exp_q [$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_txn  = 0;

    function automatic exp_t predict(int k, stim_t s);
        exp_t e;
        bit   zr;
        logic [2:0]  a;
        logic [15:0] d;
        logic        r;
        zr      = (k == 1);
        e       = '0;
        e.inst  = (k == 1);
        for (int p = 0; p < 2; p++) begin
            a = s.addr[p*3 +: 3];
            if (zr && a == 3'd0) begin
                d = 16'h0; r = 1'b1;
            end else if (s.exw && s.exd == a) begin
                d = s.exdat; r = s.exv;
            end else if (s.mw && s.md == a) begin
                d = s.mdat; r = s.mv;
            end else if (s.ww && s.wd == a) begin
                d = s.wdat; r = 1'b1;
            end else begin
                d = m_gr[k][a]; r = (m_cnt[k][a] == 0);
            end
            e.data[p*16 +: 16] = d;
            e.ready[p]         = r;
            if (s.need[p] && !r) e.stall = 1'b1;
        end
        if (s.iv && m_cnt[k][s.idst] == 3) e.stall = 1'b1;
        for (int i = 0; i < 8; i++) e.pend[i] = (m_cnt[k][i] != 0);
        e.err = m_err[k];
        return e;
    endfunction

    task automatic model_update(int k, stim_t s, logic stalled);
        bit zr, iss, wb;
        zr  = (k == 1);
        iss = s.iv && !stalled && !(zr && s.idst == 3'd0);
        wb  = s.ww && !(zr && s.wd == 3'd0);
        if (wb) m_gr[k][s.wd] = s.wdat;
        if (!(iss && wb && s.idst == s.wd)) begin
            if (iss && m_cnt[k][s.idst] < 3) m_cnt[k][s.idst] = m_cnt[k][s.idst] + 1;
            if (wb) begin
                if (m_cnt[k][s.wd] == 0) m_err[k] = 1'b1;
                else m_cnt[k][s.wd] = m_cnt[k][s.wd] - 1;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_gr[k][i]  = 16'h0;
                m_cnt[k][i] = 0;
            end
            m_err[k] = 1'b0;
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clock);
        reset = s.rst_n;  en = s.en;
        rd_need = s.need; rd_addr = s.addr;
        iss_valid = s.iv; iss_dst = s.idst;
        ex_wr = s.exw;  ex_dst = s.exd;  ex_dv = s.exv;  ex_data = s.exdat;
        mem_wr = s.mw;  mem_dst = s.md;  mem_dv = s.mv;  mem_data = s.mdat;
        wb_wr = s.ww;   wb_dst = s.wd;   wb_data = s.wdat;
        if (!s.rst_n) model_reset();
        for (int k = 0; k < 2; k++) begin
            e = predict(k, s);
            exp_q.push_back(e);
            if (s.rst_n && s.en) model_update(k, s, e.stall);
        end
    endtask

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s inst%0d txn%0d: got %h expected %h", name, inst, n_txn, act, req);
        end
    endtask

    // Monitor: combinational outputs are presented every cycle; sample mid-low-phase.
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(negedge clock);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                k = e.inst ? 1 : 0;
                check("rd_data",  k, dat_w[k],          e.data);
                check("rd_ready", k, 32'(rdy_w[k]),     32'(e.ready));
                check("stall",    k, 32'(stall_w[k]),   32'(e.stall));
                check("pend",     k, 32'(pend_w[k]),    32'(e.pend));
                check("sb_err",   k, 32'(err_w[k]),     32'(e.err));
                $display("txn %0d inst%0d data=%h rdy=%b stall=%b pend=%h err=%b",
                         n_txn, k, dat_w[k], rdy_w[k], stall_w[k], pend_w[k], err_w[k]);
                n_txn++;
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s       = '0;
        s.rst_n = 1'b1;
        s.en    = 1'b1;
        return s;
    endfunction

    function automatic logic [5:0] pair(input int a0, input int a1);
        logic [5:0] v;
        v[2:0] = 3'(a0);
        v[5:3] = 3'(a1);
        return v;
    endfunction

    initial begin
        stim_t s;
        int    pick;
        reset = 1'b0; en = 1'b0; rd_need = '0; rd_addr = '0;
        iss_valid = 1'b0; iss_dst = '0;
        ex_wr = 1'b0; ex_dst = '0; ex_dv = 1'b0; ex_data = '0;
        mem_wr = 1'b0; mem_dst = '0; mem_dv = 1'b0; mem_data = '0;
        wb_wr = 1'b0; wb_dst = '0; wb_data = '0;
        model_reset();

        s = idle(); s.rst_n = 1'b0; step(s);
        for (int i = 0; i < 8; i += 2) begin
            s = idle(); s.need = 2'b11; s.addr = pair(i, i + 1); step(s);
        end

        // Issue r3, then forward its EX result.
        s = idle(); s.iv = 1; s.idst = 3; step(s);
        s = idle(); s.need = 2'b11; s.addr = pair(3, 3);
        s.exw = 1; s.exd = 3; s.exv = 1; s.exdat = 16'h1234; step(s);

        // Load-use on r2: stall blocks issue to r1, then MEM supplies data.
        s = idle(); s.need = 2'b01; s.addr = pair(2, 0); s.iv = 1; s.idst = 1;
        s.exw = 1; s.exd = 2; s.exv = 0; step(s);
        s = idle(); s.need = 2'b01; s.addr = pair(2, 0);
        s.mw = 1; s.md = 2; s.mv = 1; s.mdat = 16'hBEEF; step(s);

        // Two writers to r5: EX wins; then fill r5's counter and stall the fourth issue.
        s = idle(); s.need = 2'b11; s.addr = pair(5, 5);
        s.exw = 1; s.exd = 5; s.exv = 1; s.exdat = 16'h0002;
        s.mw = 1; s.md = 5; s.mv = 1; s.mdat = 16'h0001; step(s);
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.iv = 1; s.idst = 5; s.addr = pair(5, 0); step(s);
        end

        // Write-first bypass on r4, then sticky error from r6.
        s = idle(); s.iv = 1; s.idst = 4; step(s);
        s = idle(); s.need = 2'b01; s.addr = pair(4, 4);
        s.ww = 1; s.wd = 4; s.wdat = 16'h00FF; step(s);
        s = idle(); s.addr = pair(4, 6); step(s);
        s = idle(); s.ww = 1; s.wd = 6; s.wdat = 16'h0066; step(s);
        s = idle(); s.addr = pair(6, 4); step(s);
        s = idle(); s.en = 0; s.ww = 1; s.wd = 7; s.wdat = 16'h7777; s.iv = 1; s.idst = 7; step(s);

        // Zero register handling.
        s = idle(); s.ww = 1; s.wd = 0; s.wdat = 16'hFFFF; s.iv = 1; s.idst = 0; step(s);
        s = idle(); s.need = 2'b11; s.addr = pair(0, 0); step(s);

        // Reset while stalled on the full r5 counter.
        s = idle(); s.iv = 1; s.idst = 5; step(s);
        s = idle(); s.rst_n = 0; s.iv = 1; s.idst = 5; step(s);
        s = idle(); s.need = 2'b11; s.addr = pair(5, 3); step(s);

        for (int n = 0; n < 600; n++) begin
            s       = idle();
            s.rst_n = ($urandom_range(0, 249) != 0);
            s.en    = ($urandom_range(0, 7) != 0);
            s.need  = 2'($urandom);
            s.addr  = 6'($urandom);
            s.iv    = ($urandom_range(0, 1) == 1);
            s.idst  = 3'($urandom);
            s.exw   = ($urandom_range(0, 4) < 2);
            s.exd   = 3'($urandom);
            s.exv   = ($urandom_range(0, 9) < 7);
            s.exdat = 16'($urandom);
            s.mw    = ($urandom_range(0, 4) < 2);
            s.md    = 3'($urandom);
            s.mv    = ($urandom_range(0, 9) < 8);
            s.mdat  = 16'($urandom);
            s.ww    = ($urandom_range(0, 4) < 2);
            s.wdat  = 16'($urandom);
            pick    = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) begin
                for (int j = 0; j < 8; j++) begin
                    if (m_cnt[0][(pick + j) % 8] > 0) begin
                        pick = (pick + j) % 8;
                        break;
                    end
                end
            end
            s.wd = 3'(pick);
            step(s);
        end

        @(negedge clock);
        #5;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
